// File: rtl/gate_operand_server.sv
// Responder for the gate column-fetch interface: stores X/Y weight columns, optional bias and per-step x/h vectors.
// Optional bias storage and LOAD_B phase are enabled by defining GATE_SRV_BIAS_EN.
module gate_operand_server #(
  parameter int INPUT_SZ  = 8,
  parameter int HIDDEN_SZ = 16,
  parameter int QN        = 6,
  parameter int QM        = 11,
  localparam int BITWIDTH       = QN + QM + 1,
  localparam int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ,
  localparam int AX             = $clog2(INPUT_SZ),
  localparam int AY             = $clog2(HIDDEN_SZ)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [BITWIDTH-1:0]          load_data,
  input  logic                         weight_reload,
  output logic                         weights_loaded,
  input  logic                         step_start,
  input  logic [BITWIDTH*INPUT_SZ-1:0] x_vec,
  input  logic [LAYER_BITWIDTH-1:0]    h_vec,
  output logic                         beginCalc,
  input  logic [AX-1:0]                colAddress_X,
  input  logic [AY-1:0]                colAddress_Y,
  output logic [LAYER_BITWIDTH-1:0]    weightMem_X,
  output logic [LAYER_BITWIDTH-1:0]    weightMem_Y,
  output logic [BITWIDTH-1:0]          inputVec,
  output logic [BITWIDTH-1:0]          prevLayerOut,
  output logic [LAYER_BITWIDTH-1:0]    biasVec,
  input  logic                         dataReady_gate,
  output logic                         step_done
);

  typedef enum logic [2:0] {
    S_LOAD_X,
    S_LOAD_Y,
`ifdef GATE_SRV_BIAS_EN
    S_LOAD_B,
`endif
    S_ARMED,
    S_RUN
  } state_t;

  state_t state, state_nxt;
  logic [AY-1:0] row_cnt, row_nxt;
  logic [AY-1:0] col_cnt, col_nxt;
  logic          last_row;
  logic          wr_x, wr_y, latch_en, begin_nxt, done_nxt;
`ifdef GATE_SRV_BIAS_EN
  logic          wr_b;
`endif

  logic [BITWIDTH-1:0] mem_x [INPUT_SZ][HIDDEN_SZ];
  logic [BITWIDTH-1:0] mem_y [HIDDEN_SZ][HIDDEN_SZ];
  logic [BITWIDTH-1:0] x_lat [INPUT_SZ];
  logic [BITWIDTH-1:0] h_lat [HIDDEN_SZ];
  logic                x_ok, y_ok;

  assign last_row = (row_cnt == AY'(HIDDEN_SZ - 1));
  assign x_ok     = (32'(colAddress_X) < INPUT_SZ);
  assign y_ok     = (32'(colAddress_Y) < HIDDEN_SZ);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_LOAD_X;
      row_cnt   <= '0;
      col_cnt   <= '0;
      beginCalc <= 1'b0;
      step_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      row_cnt   <= row_nxt;
      col_cnt   <= col_nxt;
      beginCalc <= begin_nxt;
      step_done <= done_nxt;
    end
  end

  // Loads are column-major: the row counter wraps into the column counter.
  always_comb begin
    state_nxt      = state;
    row_nxt        = row_cnt;
    col_nxt        = col_cnt;
    load_ready     = 1'b0;
    weights_loaded = 1'b0;
    wr_x           = 1'b0;
    wr_y           = 1'b0;
    latch_en       = 1'b0;
    begin_nxt      = 1'b0;
    done_nxt       = 1'b0;
`ifdef GATE_SRV_BIAS_EN
    wr_b           = 1'b0;
`endif
    case (state)
      S_LOAD_X: begin
        load_ready = 1'b1;
        if (load_valid) begin
          wr_x    = 1'b1;
          row_nxt = last_row ? '0 : row_cnt + 1'b1;
          if (last_row) begin
            if (col_cnt == AY'(INPUT_SZ - 1)) begin
              col_nxt   = '0;
              state_nxt = S_LOAD_Y;
            end else begin
              col_nxt = col_cnt + 1'b1;
            end
          end
        end
      end
      S_LOAD_Y: begin
        load_ready = 1'b1;
        if (load_valid) begin
          wr_y    = 1'b1;
          row_nxt = last_row ? '0 : row_cnt + 1'b1;
          if (last_row) begin
            if (col_cnt == AY'(HIDDEN_SZ - 1)) begin
              col_nxt   = '0;
`ifdef GATE_SRV_BIAS_EN
              state_nxt = S_LOAD_B;
`else
              state_nxt = S_ARMED;
`endif
            end else begin
              col_nxt = col_cnt + 1'b1;
            end
          end
        end
      end
`ifdef GATE_SRV_BIAS_EN
      S_LOAD_B: begin
        load_ready = 1'b1;
        if (load_valid) begin
          wr_b    = 1'b1;
          row_nxt = last_row ? '0 : row_cnt + 1'b1;
          if (last_row) state_nxt = S_ARMED;
        end
      end
`endif
      S_ARMED: begin
        weights_loaded = 1'b1;
        if (step_start) begin
          latch_en  = 1'b1;
          begin_nxt = 1'b1;
          state_nxt = S_RUN;
        end else if (weight_reload) begin
          row_nxt   = '0;
          col_nxt   = '0;
          state_nxt = S_LOAD_X;
        end
      end
      S_RUN: begin
        weights_loaded = 1'b1;
        if (dataReady_gate) begin
          done_nxt  = 1'b1;
          state_nxt = S_ARMED;
        end
      end
      default: state_nxt = S_LOAD_X;
    endcase
  end

  // Storage is deliberately left out of reset; a reset only blocks writes.
  always_ff @(posedge clock) begin
    if (!reset && wr_x) mem_x[col_cnt[AX-1:0]][row_cnt] <= load_data;
    if (!reset && wr_y) mem_y[col_cnt][row_cnt] <= load_data;
    if (!reset && latch_en) begin
      for (int i = 0; i < INPUT_SZ; i++) x_lat[i] <= x_vec[i*BITWIDTH +: BITWIDTH];
      for (int i = 0; i < HIDDEN_SZ; i++) h_lat[i] <= h_vec[i*BITWIDTH +: BITWIDTH];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      weightMem_X  <= '0;
      weightMem_Y  <= '0;
      inputVec     <= '0;
      prevLayerOut <= '0;
    end else begin
      for (int r = 0; r < HIDDEN_SZ; r++) begin
        weightMem_X[r*BITWIDTH +: BITWIDTH] <= x_ok ? mem_x[colAddress_X][r] : '0;
        weightMem_Y[r*BITWIDTH +: BITWIDTH] <= y_ok ? mem_y[colAddress_Y][r] : '0;
      end
      inputVec     <= x_ok ? x_lat[colAddress_X] : '0;
      prevLayerOut <= y_ok ? h_lat[colAddress_Y] : '0;
    end
  end

`ifdef GATE_SRV_BIAS_EN
  logic [BITWIDTH-1:0] bias_mem [HIDDEN_SZ];

  always_ff @(posedge clock) begin
    if (!reset && wr_b) bias_mem[row_cnt] <= load_data;
  end

  always_comb begin
    biasVec = '0;
    for (int r = 0; r < HIDDEN_SZ; r++) biasVec[r*BITWIDTH +: BITWIDTH] = bias_mem[r];
  end
`else
  assign biasVec = '0;
`endif

endmodule

// File: tb/tb_gate_operand_server.sv
// Self-checking bench for gate_operand_server: table-driven column reads, step sequencing and random reloads.
module tb_gate_operand_server;

  localparam int IS = 8;
  localparam int HS = 16;
  localparam int BW = 18;
  localparam int LW = BW * HS;
  localparam int NX = IS * HS;
  localparam int NY = HS * HS;
`ifdef GATE_SRV_BIAS_EN
  localparam int NB = HS;
`else
  localparam int NB = 0;
`endif
  localparam int NTOT = NX + NY + NB;

  logic              clock = 1'b0;
  logic              reset;
  logic              load_valid;
  logic              load_ready;
  logic [BW-1:0]     load_data;
  logic              weight_reload;
  logic              weights_loaded;
  logic              step_start;
  logic [BW*IS-1:0]  x_vec;
  logic [LW-1:0]     h_vec;
  logic              beginCalc;
  logic [2:0]        colAddress_X;
  logic [3:0]        colAddress_Y;
  logic [LW-1:0]     weightMem_X;
  logic [LW-1:0]     weightMem_Y;
  logic [BW-1:0]     inputVec;
  logic [BW-1:0]     prevLayerOut;
  logic [LW-1:0]     biasVec;
  logic              dataReady_gate;
  logic              step_done;

  gate_operand_server dut (
    .clock(clock), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .weight_reload(weight_reload), .weights_loaded(weights_loaded),
    .step_start(step_start), .x_vec(x_vec), .h_vec(h_vec), .beginCalc(beginCalc),
    .colAddress_X(colAddress_X), .colAddress_Y(colAddress_Y),
    .weightMem_X(weightMem_X), .weightMem_Y(weightMem_Y),
    .inputVec(inputVec), .prevLayerOut(prevLayerOut), .biasVec(biasVec),
    .dataReady_gate(dataReady_gate), .step_done(step_done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference storage: word n of a load lands at column n/HS, row n%HS.
  logic [BW-1:0] mx [IS][HS];
  logic [BW-1:0] my [HS][HS];
  logic [BW-1:0] mb [HS];
  logic [BW-1:0] x_m [IS];
  logic [BW-1:0] h_m [HS];

  typedef struct {
    int            ax;
    int            ay;
    logic [BW-1:0] x_row0;
    logic [BW-1:0] x_row15;
    logic [BW-1:0] y_row0;
    logic [BW-1:0] y_row15;
  } rd_vec_t;

  rd_vec_t tbl [5];

  task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] col_x(input int c);
    logic [LW-1:0] v;
    for (int r = 0; r < HS; r++) v[r*BW +: BW] = mx[c][r];
    return v;
  endfunction

  function automatic logic [LW-1:0] col_y(input int c);
    logic [LW-1:0] v;
    for (int r = 0; r < HS; r++) v[r*BW +: BW] = my[c][r];
    return v;
  endfunction

  function automatic logic [LW-1:0] exp_bias();
    logic [LW-1:0] v;
    v = '0;
`ifdef GATE_SRV_BIAS_EN
    for (int r = 0; r < HS; r++) v[r*BW +: BW] = mb[r];
`endif
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input bit gaps, input bit rnd);
    logic [BW-1:0] d;
    for (int k = 0; k < NTOT; k++) begin
      d = rnd ? BW'($urandom) : BW'(k + 1);
      if (k < NX) mx[k / HS][k % HS] = d;
      else if (k < NX + NY) my[(k - NX) / HS][(k - NX) % HS] = d;
      else mb[k - NX - NY] = d;
      if (k == NTOT - 1) begin
        checkOutput("ready_before_last", LW'(load_ready), LW'(1));
        checkOutput("loaded_before_last", LW'(weights_loaded), LW'(0));
      end
      load_valid = 1'b1;
      load_data  = d;
      tick();
      load_valid = 1'b0;
      load_data  = BW'($urandom);
      if (gaps) tick();
    end
    checkOutput("loaded_after_last", LW'(weights_loaded), LW'(1));
    checkOutput("ready_after_last", LW'(load_ready), LW'(0));
  endtask

  task automatic random_reads(input int n);
    for (int i = 0; i < n; i++) begin
      int ax, ay;
      ax = $urandom_range(0, IS - 1);
      ay = $urandom_range(0, HS - 1);
      colAddress_X = 3'(ax);
      colAddress_Y = 4'(ay);
      tick();
      checkOutput("rand_col_x", weightMem_X, col_x(ax));
      checkOutput("rand_col_y", weightMem_Y, col_y(ay));
      checkOutput("bias_vec", biasVec, exp_bias());
    end
  endtask

  task automatic set_vectors();
    for (int i = 0; i < IS; i++) x_vec[i*BW +: BW] = x_m[i];
    for (int i = 0; i < HS; i++) h_vec[i*BW +: BW] = h_m[i];
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_data = '0; weight_reload = 1'b0;
    step_start = 1'b0; x_vec = '0; h_vec = '0; colAddress_X = '0; colAddress_Y = '0;
    dataReady_gate = 1'b0;

    // Expected column ends under the 1..N load: X col c row r = c*16+r+1, Y = 128+c*16+r+1.
    tbl[0] = '{3, 0, 18'd49, 18'd64, 18'd129, 18'd144};
    tbl[1] = '{0, 15, 18'd1, 18'd16, 18'd369, 18'd384};
    tbl[2] = '{7, 5, 18'd113, 18'd128, 18'd209, 18'd224};
    tbl[3] = '{5, 9, 18'd81, 18'd96, 18'd273, 18'd288};
    tbl[4] = '{1, 1, 18'd17, 18'd32, 18'd145, 18'd160};

    tick(); tick();
    checkOutput("rst_load_ready", LW'(load_ready), LW'(1));
    checkOutput("rst_weights_loaded", LW'(weights_loaded), LW'(0));
    checkOutput("rst_beginCalc", LW'(beginCalc), LW'(0));
    checkOutput("rst_step_done", LW'(step_done), LW'(0));
    checkOutput("rst_weightMem_X", weightMem_X, '0);
    checkOutput("rst_inputVec", LW'(inputVec), LW'(0));
    reset = 1'b0;
    tick();

    // Abort a partial X load, with a stray step_start that must be ignored.
    for (int k = 0; k < 50; k++) begin
      load_valid = 1'b1;
      load_data  = BW'(1000 + k);
      step_start = (k == 10);
      tick();
    end
    load_valid = 1'b0;
    step_start = 1'b0;
    checkOutput("load_beginCalc_ignored", LW'(beginCalc), LW'(0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("abort_load_ready", LW'(load_ready), LW'(1));
    checkOutput("abort_weights_loaded", LW'(weights_loaded), LW'(0));

    applyStimulus(1'b1, 1'b0);
    checkOutput("bias_after_load", biasVec, exp_bias());

    for (int i = 0; i < 5; i++) begin
      colAddress_X = 3'(tbl[i].ax);
      colAddress_Y = 4'(tbl[i].ay);
      if (i > 0) begin
        #2;
        checkOutput("x_still_registered", LW'(weightMem_X[0 +: BW]), LW'(tbl[i-1].x_row0));
      end
      tick();
      checkOutput("tbl_x_row0", LW'(weightMem_X[0 +: BW]), LW'(tbl[i].x_row0));
      checkOutput("tbl_x_row15", LW'(weightMem_X[15*BW +: BW]), LW'(tbl[i].x_row15));
      checkOutput("tbl_y_row0", LW'(weightMem_Y[0 +: BW]), LW'(tbl[i].y_row0));
      checkOutput("tbl_y_row15", LW'(weightMem_Y[15*BW +: BW]), LW'(tbl[i].y_row15));
      checkOutput("tbl_col_x", weightMem_X, col_x(tbl[i].ax));
      checkOutput("tbl_col_y", weightMem_Y, col_y(tbl[i].ay));
    end

    // Step with simultaneous reload: the step wins.
    for (int i = 0; i < IS; i++) x_m[i] = BW'($urandom);
    for (int i = 0; i < HS; i++) h_m[i] = BW'($urandom);
    x_m[2] = 18'h00A00;
    set_vectors();
    colAddress_X = 3'd2;
    step_start = 1'b1;
    weight_reload = 1'b1;
    tick();
    step_start = 1'b0;
    weight_reload = 1'b0;
    x_vec = ~x_vec;
    h_vec = ~h_vec;
    checkOutput("step_beginCalc_hi", LW'(beginCalc), LW'(1));
    checkOutput("step_reload_dropped", LW'(weights_loaded), LW'(1));
    checkOutput("step_load_ready_lo", LW'(load_ready), LW'(0));
    tick();
    checkOutput("step_beginCalc_lo", LW'(beginCalc), LW'(0));
    checkOutput("step_inputVec", LW'(inputVec), LW'(18'h00A00));

    // In RUN everything but dataReady_gate is ignored.
    step_start = 1'b1; weight_reload = 1'b1; load_valid = 1'b1; load_data = '1;
    tick();
    step_start = 1'b0; weight_reload = 1'b0; load_valid = 1'b0;
    checkOutput("run_weights_loaded", LW'(weights_loaded), LW'(1));
    tick();
    checkOutput("run_no_beginCalc", LW'(beginCalc), LW'(0));
    checkOutput("run_load_ready", LW'(load_ready), LW'(0));
    for (int k = 0; k < HS; k++) begin
      colAddress_Y = 4'(k);
      colAddress_X = 3'(k % IS);
      tick();
      checkOutput("run_prevLayerOut", LW'(prevLayerOut), LW'(h_m[k]));
      checkOutput("run_inputVec", LW'(inputVec), LW'(x_m[k % IS]));
    end
    random_reads(4);
    dataReady_gate = 1'b1;
    tick();
    dataReady_gate = 1'b0;
    checkOutput("step_done_hi", LW'(step_done), LW'(1));
    checkOutput("armed_after_run", LW'(weights_loaded), LW'(1));
    tick();
    checkOutput("step_done_lo", LW'(step_done), LW'(0));

    // Random steps with random gate latency.
    for (int s = 0; s < 6; s++) begin
      int lat, ax, ay;
      for (int i = 0; i < IS; i++) x_m[i] = BW'($urandom);
      for (int i = 0; i < HS; i++) h_m[i] = BW'($urandom);
      set_vectors();
      step_start = 1'b1;
      tick();
      step_start = 1'b0;
      checkOutput("rs_beginCalc", LW'(beginCalc), LW'(1));
      lat = $urandom_range(1, 4);
      for (int c = 0; c < lat; c++) begin
        ax = $urandom_range(0, IS - 1);
        ay = $urandom_range(0, HS - 1);
        colAddress_X = 3'(ax);
        colAddress_Y = 4'(ay);
        tick();
        checkOutput("rs_inputVec", LW'(inputVec), LW'(x_m[ax]));
        checkOutput("rs_prevLayerOut", LW'(prevLayerOut), LW'(h_m[ay]));
        checkOutput("rs_no_done", LW'(step_done), LW'(0));
      end
      dataReady_gate = 1'b1;
      tick();
      dataReady_gate = 1'b0;
      checkOutput("rs_step_done", LW'(step_done), LW'(1));
    end

    // Reset in the middle of a step aborts it without a step_done.
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    reset = 1'b1;
    dataReady_gate = 1'b1;
    tick();
    reset = 1'b0;
    dataReady_gate = 1'b0;
    checkOutput("mid_run_rst_done", LW'(step_done), LW'(0));
    checkOutput("mid_run_rst_ready", LW'(load_ready), LW'(1));
    checkOutput("mid_run_rst_loaded", LW'(weights_loaded), LW'(0));
    dataReady_gate = 1'b1;
    tick();
    dataReady_gate = 1'b0;
    tick();
    checkOutput("no_done_after_abort", LW'(step_done), LW'(0));
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    tick();
    checkOutput("no_begin_in_load", LW'(beginCalc), LW'(0));

    applyStimulus(1'b0, 1'b1);
    random_reads(20);

    // Reload alone from ARMED restarts the weight load.
    weight_reload = 1'b1;
    tick();
    weight_reload = 1'b0;
    checkOutput("reload_ready", LW'(load_ready), LW'(1));
    checkOutput("reload_loaded", LW'(weights_loaded), LW'(0));
    applyStimulus(1'b1, 1'b1);
    random_reads(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
